rr_port_arbiter: RTL
====================

// Module: rr_port_arbiter
// PURPOSE
//  Parametrised wormhole round-robin arbiter for one router output port. Each
//  input's next-hop address is compared with PORT_ADDR. One requester is
//  granted and locked until its tail flit transfers. The rotating pointer then
//  advances past the winner. One instance per output port; grant_idx_o drives
//  the crossbar select.
// PARAMETERS
//  NUM_REQ    5   number of input channels (>=2)
//  ADDR_W     3   next-hop address width
//  PORT_ADDR  0   address value this output port serves
//  SELF_IDX   0   input index barred from this port (no U-turn); NUM_REQ = none
// PORTS
//  clk          in   1                 clock, rising edge
//  reset        in   1                 asynchronous, active-low reset
//  req_valid_i  in   NUM_REQ           per-input head/body flit valid
//  req_addr_i   in   NUM_REQ*ADDR_W    per-input next-hop addr; input k at [k*ADDR_W +: ADDR_W]
//  req_tail_i   in   NUM_REQ           per-input flit is tail
//  out_ready_i  in   1                 downstream accepts flit this cycle
//  grant_o      out  NUM_REQ           one-hot grant, registered
//  grant_idx_o  out  $clog2(NUM_REQ)   binary index of grant_o (crossbar select)
//  grant_vld_o  out  1                 a grant is held
//  xfer_o       out  1                 flit transferred this cycle (comb)
// BEHAVIOUR
//  - Reset (reset==0, async): grant_o=0, grant_idx_o=0, grant_vld_o=0, state IDLE,
//    ptr=NUM_REQ-1, so input 0 has first priority. Reset mid-packet drops the
//    lock; there is no recovery of a partial packet.
//  - desire[k] = req_valid_i[k] & (addr_k==PORT_ADDR) & (k!=SELF_IDX).
//  - Pick: first desire[k] searching (ptr+1)..NUM_REQ-1, then wrapping 0..ptr;
//    the last winner (ptr) has lowest priority.
//  - xfer_o = grant_vld_o & req_valid_i[grant_idx_o] & out_ready_i.
//  - FSM IDLE: if any desire, register pick into grant_o/grant_idx_o, set
//    grant_vld_o, go LOCKED. Latency: request to grant = 1 clk.
//  - FSM LOCKED: grant holds regardless of the granted input's address or
//    valid (wormhole).
//    * xfer with req_tail_i[grant_idx_o]=1: ptr<=grant_idx_o. Re-arbitrate
//      this cycle with the updated ptr, using desire of all inputs.
//      - any winner: load it, stay LOCKED (no bubble between packets);
//      - none: clear grant, go IDLE.
//    * xfer, not tail: hold.
//    * granted input valid low or out_ready_i low: hold, no state change.
//  - Single-flit packet (head is tail): grant released after 1 xfer.
//  - ptr changes only on tail xfer, never on grant alone.
//  - grant_o is always zero or one-hot; grant_idx_o is valid only while grant_vld_o=1.
//  - Simultaneous requests: resolved solely by pointer order; no age or
//    weighting.
// STRUCTURE
//  - noc_arb_pkg: port address constants (N=0,S=1,W=2,E=3,L=4), IDX_W
//    function, arb_state_e {IDLE,LOCKED}.
//  - Sub-module rr_pick (combinational): inputs desire[NUM_REQ], ptr; outputs
//    found, idx, onehot. Double-width masked priority encode.
//  - Top: desire compare, FSM, ptr/grant registers.
// TESTING
//  1. Reset release, no requests -> grant_vld_o=0, grant_o=0 forever.
//  2. NUM_REQ=5, inputs 1,3 desire at cycle 0 -> cycle 1 grant_o=5'b00010.
//     Tail xfer on input 1 -> next cycle grant_o=5'b01000, no idle cycle.
//  3. Input 2 sends 4-flit packet, out_ready_i low for 3 cycles mid-packet ->
//     grant held 7 cycles; input 4 requesting throughout is not granted until
//     after the tail.
//  4. All 4 eligible inputs request continuously with 1-flit packets (SELF_IDX=0
//     disabled) -> grant order 1,2,3,4,1 (wrap), each exactly once per 4 grants.
//  5. Input 0 addr==PORT_ADDR with SELF_IDX=0, others idle -> never granted.
//     Wrong address on any input -> never granted.
//  6. Assert reset mid-packet while LOCKED on input 3 -> outputs 0 asynchronously.
//     After release, ptr=4, so input 0 wins if requesting.

Source files
------------

// File: rtl/noc_arb_pkg.sv
// noc_arb_pkg
// Shared constants and types for the NoC output-port arbiters.
// Holds the router port address map, the index-width helper and the arbiter FSM state type.

package noc_arb_pkg;

   // Router port addresses as carried in a flit's next-hop field.
   localparam int PORT_N    = 0;
   localparam int PORT_S    = 1;
   localparam int PORT_W    = 2;
   localparam int PORT_E    = 3;
   localparam int PORT_L    = 4;
   localparam int NUM_PORTS = 5;

   // IDLE waits for a requester. LOCKED holds one input until its tail flit has gone.
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Returns the bits needed for a binary index over n items.
   // The result is never less than one, so a select bus always exists.
   function automatic int IDX_W(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker.
// The search starts just above the pointer and wraps to index 0. The input at the pointer
// itself is searched last.
// The wrap is handled by encoding a double-width vector:
//   - the low half holds only the requesters above the pointer;
//   - the high half holds every requester.
// The lowest set bit of that vector is the winner.

module rr_pick
   import noc_arb_pkg::*;
#(
   parameter int NUM_REQ = 5,
   parameter int SEL_W   = IDX_W(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] desire,
   input  logic [SEL_W-1:0]   ptr,
   output logic               found,
   output logic [SEL_W-1:0]   idx,
   output logic [NUM_REQ-1:0] onehot
);

   logic [NUM_REQ-1:0]   upper_mask;
   logic [2*NUM_REQ-1:0] dbl;

   // Keep only the requesters strictly above the pointer for the first pass of the search.
   always_comb begin
      upper_mask = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         upper_mask[k] = (k > int'(ptr));
      end
      dbl = {desire, desire & upper_mask};
   end

   // Find the lowest set bit of the double-width vector and fold it back to an input index.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
         if (dbl[j]) begin
            found = 1'b1;
            idx   = (j >= NUM_REQ) ? SEL_W'(j - NUM_REQ) : SEL_W'(j);
         end
      end
   end

   // Expand the winning index into the one-hot grant vector (all zero when nothing was found).
   always_comb begin
      onehot = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         onehot[k] = found && (idx == SEL_W'(k));
      end
   end

endmodule

// File: rtl/rr_port_arbiter.sv
// rr_port_arbiter
// Wormhole round-robin arbiter for one router output port.
//
// An input is eligible when all of these hold:
//   - it is valid;
//   - its next-hop address equals PORT_ADDR;
//   - it is not the barred SELF_IDX input.
//
// The winner stays locked until its tail flit transfers. On that edge the pointer moves to
// the winner and the port is re-arbitrated at once, so back-to-back packets need no idle
// cycle between them.
// grant_idx_o drives the crossbar select.

module rr_port_arbiter
   import noc_arb_pkg::*;
#(
   parameter int NUM_REQ   = 5,
   parameter int ADDR_W    = 3,
   parameter int PORT_ADDR = PORT_N,
   parameter int SELF_IDX  = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
   input  logic [NUM_REQ-1:0]          req_tail_i,
   input  logic                        out_ready_i,
   output logic [NUM_REQ-1:0]          grant_o,
   output logic [IDX_W(NUM_REQ)-1:0]   grant_idx_o,
   output logic                        grant_vld_o,
   output logic                        xfer_o
);

   localparam int                SEL_W    = IDX_W(NUM_REQ);
   localparam logic [SEL_W-1:0]  PTR_INIT = SEL_W'(NUM_REQ - 1);
   localparam logic [ADDR_W-1:0] MY_ADDR  = ADDR_W'(PORT_ADDR);

   arb_state_e         state;
   arb_state_e         state_next;
   logic [SEL_W-1:0]   ptr;
   logic [NUM_REQ-1:0] desire;
   logic               granted_valid;
   logic               granted_tail;
   logic               tail_xfer;
   logic [SEL_W-1:0]   pick_ptr;
   logic               pick_found;
   logic [SEL_W-1:0]   pick_idx;
   logic [NUM_REQ-1:0] pick_onehot;
   logic               load_grant;
   logic               clear_grant;

   // Mark each input that wants this port and is allowed to use it.
   always_comb begin
      desire = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         desire[k] = req_valid_i[k]
                     && (req_addr_i[k*ADDR_W +: ADDR_W] == MY_ADDR)
                     && (k != SELF_IDX);
      end
   end

   // The one-hot grant selects the held input's valid and tail bits without a variable index.
   assign granted_valid = |(req_valid_i & grant_o);
   assign granted_tail  = |(req_tail_i & grant_o);
   assign grant_vld_o   = (state == LOCKED);
   assign xfer_o        = grant_vld_o & granted_valid & out_ready_i;
   assign tail_xfer     = xfer_o & granted_tail;

   // On a tail transfer, the pick already uses the winner as the pointer. The next packet then
   // treats the just-finished input as lowest priority on this same edge.
   assign pick_ptr = tail_xfer ? grant_idx_o : ptr;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .SEL_W   (SEL_W)
   ) u_pick (
      .desire  (desire),
      .ptr     (pick_ptr),
      .found   (pick_found),
      .idx     (pick_idx),
      .onehot  (pick_onehot)
   );

   // FSM state register. Reset drops any lock, so a partial packet is abandoned.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   // A lock is released only by a tail transfer with no other eligible requester waiting.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_next = LOCKED;
            end
         end
         LOCKED: begin
            if (tail_xfer && !pick_found) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output decode: decide whether the grant register loads a new winner or clears.
   always_comb begin
      load_grant  = 1'b0;
      clear_grant = 1'b0;
      case (state)
         IDLE: begin
            load_grant = pick_found;
         end
         LOCKED: begin
            load_grant  = tail_xfer && pick_found;
            clear_grant = tail_xfer && !pick_found;
         end
         default: begin
            clear_grant = 1'b1;
         end
      endcase
   end

   // Grant and pointer registers.
   // The pointer moves only when a tail flit transfers, never when a grant is merely issued.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_o     <= '0;
         grant_idx_o <= '0;
         ptr         <= PTR_INIT;
      end else begin
         if (tail_xfer) begin
            ptr <= grant_idx_o;
         end
         if (load_grant) begin
            grant_o     <= pick_onehot;
            grant_idx_o <= pick_idx;
         end else if (clear_grant) begin
            grant_o     <= '0;
            grant_idx_o <= '0;
         end
      end
   end

endmodule
